// File: rtl/sequence_checker.sv
// Receive-side pattern checker: hunts for the sync byte, verifies a run of
// predicted bytes, then tracks matches/errors while locked.
module sequence_checker #(
   parameter logic [7:0] SYNC_BYTE    = 8'hAF,
   parameter logic [7:0] STEP         = 8'h00,
   parameter int         LOCK_COUNT   = 3,
   parameter int         UNLOCK_COUNT = 2,
   parameter int         CNT_W        = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic [7:0]       data,
   input  logic             clear,
   output logic             locked,
   output logic [1:0]       state,
   output logic             match_pulse,
   output logic             error_pulse,
   output logic [CNT_W-1:0] match_count,
   output logic [CNT_W-1:0] error_count
);

   localparam int RUN_W  = $clog2(LOCK_COUNT + 1);
   localparam int MISS_W = $clog2(UNLOCK_COUNT + 1);

   typedef enum logic [1:0] {
      HUNT   = 2'd0,
      VERIFY = 2'd1,
      LOCKED = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [7:0]         expByte_q, expByte_d;
   logic [RUN_W-1:0]   run_q, run_d;
   logic [MISS_W-1:0]  miss_q, miss_d;
   logic               matchPulse_q, matchPulse_d;
   logic               errorPulse_q, errorPulse_d;
   logic [CNT_W-1:0]   matchCnt_q, matchCnt_d;
   logic [CNT_W-1:0]   errorCnt_q, errorCnt_d;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= HUNT;
         expByte_q    <= SYNC_BYTE;
         run_q        <= '0;
         miss_q       <= '0;
         matchPulse_q <= 1'b0;
         errorPulse_q <= 1'b0;
         matchCnt_q   <= '0;
         errorCnt_q   <= '0;
      end else begin
         state_q      <= state_d;
         expByte_q    <= expByte_d;
         run_q        <= run_d;
         miss_q       <= miss_d;
         matchPulse_q <= matchPulse_d;
         errorPulse_q <= errorPulse_d;
         matchCnt_q   <= matchCnt_d;
         errorCnt_q   <= errorCnt_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      expByte_d    = expByte_q;
      run_d        = run_q;
      miss_d       = miss_q;
      matchPulse_d = 1'b0;
      errorPulse_d = 1'b0;
      matchCnt_d   = matchCnt_q;
      errorCnt_d   = errorCnt_q;

      if (enable) begin
         case (state_q)
            HUNT, VERIFY: begin
               if (state_q == VERIFY && data == expByte_q) begin
                  expByte_d = expByte_q + STEP;
                  run_d     = run_q + 1'b1;
                  if (run_d == RUN_W'(LOCK_COUNT))
                     state_d = LOCKED;
               end else if (data == SYNC_BYTE) begin
                  // A sync byte that breaks a verify run restarts acquisition.
                  expByte_d = SYNC_BYTE + STEP;
                  run_d     = RUN_W'(1);
                  state_d   = (LOCK_COUNT == 1) ? LOCKED : VERIFY;
               end else begin
                  expByte_d = SYNC_BYTE;
                  run_d     = '0;
                  state_d   = HUNT;
               end
            end
            LOCKED: begin
               expByte_d = expByte_q + STEP;
               if (data == expByte_q) begin
                  miss_d       = '0;
                  matchPulse_d = 1'b1;
                  if (matchCnt_q != '1)
                     matchCnt_d = matchCnt_q + 1'b1;
               end else begin
                  errorPulse_d = 1'b1;
                  if (errorCnt_q != '1)
                     errorCnt_d = errorCnt_q + 1'b1;
                  miss_d = miss_q + 1'b1;
                  if (miss_d == MISS_W'(UNLOCK_COUNT)) begin
                     state_d   = HUNT;
                     run_d     = '0;
                     miss_d    = '0;
                     expByte_d = SYNC_BYTE;
                  end
               end
            end
            default: begin
               state_d   = HUNT;
               expByte_d = SYNC_BYTE;
               run_d     = '0;
               miss_d    = '0;
            end
         endcase
      end

      // Clear wins over any increment but leaves the pulses intact.
      if (clear) begin
         matchCnt_d = '0;
         errorCnt_d = '0;
      end
   end

   assign locked      = (state_q == LOCKED);
   assign state       = state_q;
   assign match_pulse = matchPulse_q;
   assign error_pulse = errorPulse_q;
   assign match_count = matchCnt_q;
   assign error_count = errorCnt_q;

endmodule

// File: tb/tb_sequence_checker.sv
// Self-checking bench for sequence_checker: four parameterisations share one
// stimulus bus; each phase checks the instance whose pattern it exercises.
module tb_sequence_checker;

   logic       clk;
   logic       reset;
   logic       enable;
   logic [7:0] data;
   logic       clear;

   int errors;
   int checks;

   logic        dLocked, iLocked, wLocked, sLocked;
   logic [1:0]  dState, iState, wState, sState;
   logic        dMp, iMp, wMp, sMp;
   logic        dEp, iEp, wEp, sEp;
   logic [15:0] dMc, dEc, iMc, iEc, wMc, wEc;
   logic [3:0]  sMc, sEc;

   sequence_checker u_def (
      .clk(clk), .reset(reset), .enable(enable), .data(data), .clear(clear),
      .locked(dLocked), .state(dState), .match_pulse(dMp), .error_pulse(dEp),
      .match_count(dMc), .error_count(dEc)
   );

   sequence_checker #(.STEP(8'h01)) u_inc (
      .clk(clk), .reset(reset), .enable(enable), .data(data), .clear(clear),
      .locked(iLocked), .state(iState), .match_pulse(iMp), .error_pulse(iEp),
      .match_count(iMc), .error_count(iEc)
   );

   sequence_checker #(.SYNC_BYTE(8'hFE), .STEP(8'h01)) u_wrap (
      .clk(clk), .reset(reset), .enable(enable), .data(data), .clear(clear),
      .locked(wLocked), .state(wState), .match_pulse(wMp), .error_pulse(wEp),
      .match_count(wMc), .error_count(wEc)
   );

   sequence_checker #(.CNT_W(4)) u_sat (
      .clk(clk), .reset(reset), .enable(enable), .data(data), .clear(clear),
      .locked(sLocked), .state(sState), .match_pulse(sMp), .error_pulse(sEp),
      .match_count(sMc), .error_count(sEc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        en;
      logic [7:0]  d;
      logic        clr;
      logic [1:0]  expState;
      logic        expLocked;
      logic        expMp;
      logic        expEp;
      logic [15:0] expMc;
      logic [15:0] expEc;
   } vec_t;

   vec_t vecs [18];

   // Drive one cycle of inputs after the falling edge; return 1ns past the
   // following rising edge so outputs can be sampled safely.
   task automatic applyStimulus(input logic en, input logic [7:0] d, input logic clr);
      @(negedge clk);
      enable = en;
      data   = d;
      clear  = clr;
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   task automatic doReset();
      @(negedge clk);
      enable = 1'b0;
      clear  = 1'b0;
      reset  = 1'b1;
      #2;
      reset  = 1'b0;
   endtask

   initial begin
      errors = 0;
      checks = 0;
      reset  = 1'b1;
      enable = 1'b0;
      data   = 8'hAF;
      clear  = 1'b0;

      // Reset and idle with a sync byte present but unqualified.
      repeat (3) @(posedge clk);
      #1;
      checkOutput("rst_state", dState, 2'd0);
      checkOutput("rst_locked", dLocked, 1'b0);
      checkOutput("rst_mc", dMc, 16'd0);
      checkOutput("rst_ec", dEc, 16'd0);
      checkOutput("rst_pulses", {dMp, dEp}, 2'b00);
      @(negedge clk);
      reset = 1'b0;
      applyStimulus(1'b0, 8'hAF, 1'b0);
      checkOutput("idle_state", dState, 2'd0);
      checkOutput("idle_mp", dMp, 1'b0);

      // Default-parameter table: lock, matches, hold, errors, unlock, re-hunt.
      //            en    d      clr   st    lk    mp    ep    mc     ec
      vecs[0]  = '{1'b0, 8'hAF, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0};
      vecs[1]  = '{1'b1, 8'hAF, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0};
      vecs[2]  = '{1'b1, 8'hAF, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0};
      vecs[3]  = '{1'b1, 8'hAF, 1'b0, 2'd2, 1'b1, 1'b0, 1'b0, 16'd0, 16'd0};
      vecs[4]  = '{1'b1, 8'hAF, 1'b0, 2'd2, 1'b1, 1'b1, 1'b0, 16'd1, 16'd0};
      vecs[5]  = '{1'b1, 8'hAF, 1'b0, 2'd2, 1'b1, 1'b1, 1'b0, 16'd2, 16'd0};
      vecs[6]  = '{1'b0, 8'h00, 1'b0, 2'd2, 1'b1, 1'b0, 1'b0, 16'd2, 16'd0};
      vecs[7]  = '{1'b1, 8'hAF, 1'b0, 2'd2, 1'b1, 1'b1, 1'b0, 16'd3, 16'd0};
      vecs[8]  = '{1'b1, 8'h00, 1'b0, 2'd2, 1'b1, 1'b0, 1'b1, 16'd3, 16'd1};
      vecs[9]  = '{1'b1, 8'hAF, 1'b0, 2'd2, 1'b1, 1'b1, 1'b0, 16'd4, 16'd1};
      vecs[10] = '{1'b1, 8'h00, 1'b0, 2'd2, 1'b1, 1'b0, 1'b1, 16'd4, 16'd2};
      vecs[11] = '{1'b1, 8'h00, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 16'd4, 16'd3};
      vecs[12] = '{1'b1, 8'h00, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 16'd4, 16'd3};
      vecs[13] = '{1'b1, 8'hAF, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0, 16'd4, 16'd3};
      vecs[14] = '{1'b1, 8'h00, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 16'd4, 16'd3};
      vecs[15] = '{1'b1, 8'hAF, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0, 16'd4, 16'd3};
      vecs[16] = '{1'b1, 8'hAF, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0, 16'd4, 16'd3};
      vecs[17] = '{1'b1, 8'hAF, 1'b1, 2'd2, 1'b1, 1'b0, 1'b0, 16'd0, 16'd0};

      for (int i = 0; i < 18; i++) begin
         applyStimulus(vecs[i].en, vecs[i].d, vecs[i].clr);
         checkOutput($sformatf("vec%0d_state", i), dState, vecs[i].expState);
         checkOutput($sformatf("vec%0d_locked", i), dLocked, vecs[i].expLocked);
         checkOutput($sformatf("vec%0d_mp", i), dMp, vecs[i].expMp);
         checkOutput($sformatf("vec%0d_ep", i), dEp, vecs[i].expEp);
         checkOutput($sformatf("vec%0d_mc", i), dMc, vecs[i].expMc);
         checkOutput($sformatf("vec%0d_ec", i), dEc, vecs[i].expEc);
      end

      // Incrementing pattern locks on AF, B0, B1.
      doReset();
      applyStimulus(1'b1, 8'hAF, 1'b0);
      applyStimulus(1'b1, 8'hB0, 1'b0);
      checkOutput("inc_verify", iState, 2'd1);
      applyStimulus(1'b1, 8'hB1, 1'b0);
      checkOutput("inc_locked", iLocked, 1'b1);
      applyStimulus(1'b1, 8'hB2, 1'b0);
      checkOutput("inc_mp", iMp, 1'b1);
      checkOutput("inc_mc", iMc, 16'd1);

      // A broken run before lock drops back to HUNT without counting errors.
      doReset();
      applyStimulus(1'b1, 8'hAF, 1'b0);
      applyStimulus(1'b1, 8'hB0, 1'b0);
      applyStimulus(1'b1, 8'hB2, 1'b0);
      checkOutput("inc_break_state", iState, 2'd0);
      checkOutput("inc_break_ec", iEc, 16'd0);
      checkOutput("inc_break_ep", iEp, 1'b0);

      // A sync byte that mismatches in VERIFY restarts the run.
      doReset();
      applyStimulus(1'b1, 8'hAF, 1'b0);
      applyStimulus(1'b1, 8'hB0, 1'b0);
      applyStimulus(1'b1, 8'hAF, 1'b0);
      checkOutput("inc_restart_state", iState, 2'd1);
      applyStimulus(1'b1, 8'hB0, 1'b0);
      checkOutput("inc_restart_run2", iState, 2'd1);
      applyStimulus(1'b1, 8'hB1, 1'b0);
      checkOutput("inc_restart_locked", iLocked, 1'b1);

      // Expected byte wraps FF -> 00.
      doReset();
      applyStimulus(1'b1, 8'hFE, 1'b0);
      checkOutput("wrap_verify", wState, 2'd1);
      applyStimulus(1'b1, 8'hFF, 1'b0);
      applyStimulus(1'b1, 8'h00, 1'b0);
      checkOutput("wrap_locked", wLocked, 1'b1);
      applyStimulus(1'b1, 8'h01, 1'b0);
      checkOutput("wrap_mp", wMp, 1'b1);
      checkOutput("wrap_ep", wEp, 1'b0);

      // Saturation on a 4-bit counter, then clear together with a beat.
      doReset();
      repeat (3) applyStimulus(1'b1, 8'hAF, 1'b0);
      checkOutput("sat_locked", sLocked, 1'b1);
      repeat (20) applyStimulus(1'b1, 8'hAF, 1'b0);
      checkOutput("sat_mc", sMc, 4'hF);
      checkOutput("sat_def_mc", dMc, 16'd20);
      applyStimulus(1'b1, 8'hAF, 1'b1);
      checkOutput("clr_mc", sMc, 4'h0);
      checkOutput("clr_mp", sMp, 1'b1);
      checkOutput("clr_locked", sLocked, 1'b1);
      applyStimulus(1'b1, 8'hAF, 1'b0);
      checkOutput("postclr_mc", sMc, 4'h1);
      checkOutput("postclr_def_mc", dMc, 16'd1);

      // Asynchronous reset while locked with an error pulse outstanding.
      applyStimulus(1'b1, 8'h00, 1'b0);
      checkOutput("pre_rst_ep", dEp, 1'b1);
      checkOutput("pre_rst_ec", dEc, 16'd1);
      @(negedge clk);
      enable = 1'b0;
      #2;
      reset = 1'b1;
      #1;
      checkOutput("async_state", dState, 2'd0);
      checkOutput("async_locked", dLocked, 1'b0);
      checkOutput("async_pulses", {dMp, dEp}, 2'b00);
      checkOutput("async_mc", dMc, 16'd0);
      checkOutput("async_ec", dEc, 16'd0);
      reset = 1'b0;
      repeat (2) applyStimulus(1'b1, 8'hAF, 1'b0);
      checkOutput("relock_verify", dState, 2'd1);
      applyStimulus(1'b1, 8'hAF, 1'b0);
      checkOutput("relock_locked", dLocked, 1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/sequence_checker.md
# sequence_checker

Receive-side counterpart of the sequence generator: samples the generator's byte stream (`data` qualified by `enable`), hunts for the sync byte, and locks onto the expected pattern. Once locked, it checks every qualified beat against the predicted byte and reports lock status, per-beat match/error pulses and saturating match/error counters. It sits directly downstream of the generator in loopback benches and on link-integrity paths.

## Interface
- `SYNC_BYTE`, 8'hAF: first byte of the pattern; the only byte that starts acquisition.
- `STEP`, 8'h00: added (mod 256) to the expected byte after each beat. 0 gives a constant stream; 1 gives an incrementing stream.
- `LOCK_COUNT`, 3: consecutive matching beats, including the sync byte, required to lock. Must be ≥1.
- `UNLOCK_COUNT`, 2: consecutive mismatches in LOCKED that drop lock. Must be ≥1.
- `CNT_W`, 16: width of the match and error counters.

Ports:
- `clk`  in  1: single clock; all logic on its rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `enable`  in  1: beat qualifier; `data` is sampled only when high.
- `data`  in  8: received byte.
- `clear`  in  1: synchronous clear of both counters.
- `locked`  out  1: high while the FSM is in LOCKED.
- `state`  out  2: FSM state (HUNT=0, VERIFY=1, LOCKED=2).
- `match_pulse`  out  1: one-cycle pulse for a matching beat in LOCKED.
- `error_pulse`  out  1: one-cycle pulse for a mismatching beat in LOCKED.
- `match_count`  out  CNT_W: saturating count of matched beats in LOCKED.
- `error_count`  out  CNT_W: saturating count of mismatched beats in LOCKED.

## Operation
- Internal registers:
  - `exp[7:0]`: expected byte.
  - `run`: consecutive-match counter, sized for LOCK_COUNT.
  - `miss`: consecutive-miss counter, sized for UNLOCK_COUNT.
- Reset values: state=HUNT, `exp`=SYNC_BYTE, `run`=0, `miss`=0, all outputs 0.
- `enable` low: all state and counters hold; both pulses are 0.
- HUNT, on a beat:
  - `data`==SYNC_BYTE: `exp`←SYNC_BYTE+STEP and `run`←1. Go to LOCKED if LOCK_COUNT==1, otherwise go to VERIFY.
  - Any other byte: stay in HUNT.
- VERIFY, on a beat:
  - `data`==`exp`: `exp`←`exp`+STEP and `run`←`run`+1. Go to LOCKED when the new `run` equals LOCK_COUNT.
  - Mismatch: evaluate the beat exactly as HUNT would. A mismatching SYNC_BYTE therefore restarts VERIFY with `run`=1; any other byte returns to HUNT.
- LOCKED, on a beat:
  - `exp` always advances by STEP, match or not.
  - Match: `miss`←0, `match_pulse`, `match_count`+1.
  - Mismatch: `error_pulse`, `error_count`+1, `miss`+1. When the new `miss` equals UNLOCK_COUNT, go to HUNT with `run`=0, `miss`=0 and `exp`=SYNC_BYTE.
- Counters saturate at all-ones; they never wrap.
- Counters change only in LOCKED. HUNT and VERIFY mismatches are not counted as errors.
- `clear`:
  - Zeroes both counters in the same edge.
  - If a beat occurs in the same cycle, the counter result is 0 but the pulse is still emitted.
  - Does not affect the FSM, `exp`, `run` or `miss`.
- `exp` arithmetic is 8-bit modulo 256 (for example 8'hFF+1 = 8'h00).

## Timing
- All outputs are registered. The effect of a beat sampled at edge N is visible after edge N.
- `locked` rises after the edge that samples the LOCK_COUNT-th consecutive match. It falls after the edge that samples the UNLOCK_COUNT-th consecutive miss.
- Pulses are high for exactly one cycle per qualifying beat. Back-to-back beats give back-to-back pulses.
- `match_pulse` and `error_pulse` are never high in the same cycle.
- Asserting `reset` mid-operation forces reset values immediately, without waiting for a clock edge. Beats are accepted from the first rising edge after deassertion.

## Test plan
- Reset and idle:
  - Stimulus: assert `reset`, then toggle `clk` with `enable`=0 and `data`=AF.
  - Required: `state`=0, `locked`=0, both counts 0, no pulses.
- Lock, defaults:
  - Stimulus: three beats of 8'hAF.
  - Required: `state` goes 1, 1, 2 and `locked`=1 after the third beat.
  - Stimulus: two further AF beats.
  - Required: two `match_pulse` cycles and `match_count`=2.
- Error tolerance and unlock:
  - Stimulus: while locked, send beats AF, 00, AF.
  - Required: one `error_pulse`, `error_count`=1, `locked` stays 1.
  - Stimulus: then send 00, 00.
  - Required: `error_count`=3 and `locked`=0 with `state`=0 after the second 00.
- Incrementing pattern, STEP=1:
  - Stimulus: AF, B0, B1.
  - Required: locked.
  - Stimulus (from reset): AF, B0, B2.
  - Required: returns to HUNT, `error_count`=0.
  - Stimulus (from reset): FE-start variant with SYNC_BYTE=FE, sending FE, FF, 00.
  - Required: locks across the wrap.
- Saturation and clear, CNT_W=4:
  - Stimulus: lock, then 20 matching beats.
  - Required: `match_count`=15.
  - Stimulus: `clear` together with a beat.
  - Required: `match_count`=0, `match_pulse`=1, `locked`=1.
- Reset mid-operation:
  - Stimulus: while locked with nonzero counts, pulse `reset` between clock edges.
  - Required: all outputs 0 immediately.
  - Stimulus: after release, three AF beats.
  - Required: relock.
